operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 210 +++++++++++++++++++++
 tb/tb_operand_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Fetches a 2x2 operand tile from the unified buffer and presents it as weights or as a row stream.
// Build option: define OPLOAD_SKEW_EN for a systolically skewed input stream.
module operand_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] base_address,
    input  logic              load_weight,
    input  logic              load_input,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] weight_00,
    output logic [DATA_W-1:0] weight_01,
    output logic [DATA_W-1:0] weight_10,
    output logic [DATA_W-1:0] weight_11,
    output logic              weight_valid,
    output logic [DATA_W-1:0] input_row0,
    output logic [DATA_W-1:0] input_row1,
    output logic              input_valid0,
    output logic              input_valid1,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = 3;
`ifdef OPLOAD_SKEW_EN
    localparam logic [CNT_W-1:0] IN_LAST = CNT_W'(2);
`else
    localparam logic [CNT_W-1:0] IN_LAST = CNT_W'(1);
`endif

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         is_w_q, is_w_d;
    logic                         arm_q;
    logic                         lw_q, li_q;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic                         rd_en_q, rd_en_d;
    logic [3:0][DATA_W-1:0]       tile_q, tile_d;
    logic [DATA_W-1:0]            w00_q, w01_q, w10_q, w11_q;
    logic [DATA_W-1:0]            w00_d, w01_d, w10_d, w11_d;
    logic                         wv_q, wv_d;
    logic [DATA_W-1:0]            row0_q, row0_d, row1_q, row1_d;
    logic                         v0_q, v0_d, v1_q, v1_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         trig_w, trig_i;

    // arm_q blocks a line that was already high across reset release from triggering.
    assign trig_w = arm_q & load_weight & ~lw_q;
    assign trig_i = arm_q & load_input & ~li_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_w_q  <= 1'b0;
            arm_q   <= 1'b0;
            lw_q    <= 1'b0;
            li_q    <= 1'b0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            tile_q  <= '0;
            w00_q   <= '0;
            w01_q   <= '0;
            w10_q   <= '0;
            w11_q   <= '0;
            wv_q    <= 1'b0;
            row0_q  <= '0;
            row1_q  <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_w_q  <= is_w_d;
            arm_q   <= 1'b1;
            lw_q    <= load_weight;
            li_q    <= load_input;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            tile_q  <= tile_d;
            w00_q   <= w00_d;
            w01_q   <= w01_d;
            w10_q   <= w10_d;
            w11_q   <= w11_d;
            wv_q    <= wv_d;
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state plus the value every registered output takes in the following cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_w_d  = is_w_q;
        addr_d  = '0;
        rd_en_d = 1'b0;
        tile_d  = tile_q;
        w00_d   = w00_q;
        w01_d   = w01_q;
        w10_d   = w10_q;
        w11_d   = w11_q;
        wv_d    = 1'b0;
        row0_d  = '0;
        row1_d  = '0;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_w || trig_i) begin
                    state_d = FETCH;
                    is_w_d  = trig_w;
                    cnt_d   = '0;
                    addr_d  = base_address;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q < CNT_W'(3)) begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end
                if (cnt_q != '0) begin
                    tile_d[2'(cnt_q - CNT_W'(1))] = mem_rdata;
                end
                // The last word is still on mem_rdata here, so it bypasses the tile buffer.
                if (cnt_q == CNT_W'(4)) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                    if (is_w_q) begin
                        w00_d = tile_q[0];
                        w01_d = tile_q[1];
                        w10_d = tile_q[2];
                        w11_d = mem_rdata;
                        wv_d  = 1'b1;
                    end else begin
                        row0_d = tile_q[0];
                        v0_d   = 1'b1;
`ifndef OPLOAD_SKEW_EN
                        row1_d = tile_q[2];
                        v1_d   = 1'b1;
`endif
                    end
                end
            end
            EMIT: begin
                if (is_w_q || cnt_q == IN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        row0_d = tile_q[1];
                        v0_d   = 1'b1;
`ifdef OPLOAD_SKEW_EN
                        row1_d = tile_q[2];
`else
                        row1_d = tile_q[3];
`endif
                        v1_d   = 1'b1;
                    end else begin
                        row1_d = tile_q[3];
                        v1_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = addr_q;
    assign weight_00    = w00_q;
    assign weight_01    = w01_q;
    assign weight_10    = w10_q;
    assign weight_11    = w11_q;
    assign weight_valid = wv_q;
    assign input_row0   = row0_q;
    assign input_row1   = row1_q;
    assign input_valid0 = v0_q;
    assign input_valid1 = v1_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed and random tile transfers against a cycle-indexed model.
// Honours OPLOAD_SKEW_EN the same way the design does.
module tb_operand_loader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 13;
`ifdef OPLOAD_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] base_address;
    logic              load_weight;
    logic              load_input;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] weight_00, weight_01, weight_10, weight_11;
    logic              weight_valid;
    logic [DATA_W-1:0] input_row0, input_row1;
    logic              input_valid0, input_valid1;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mw [4];
    int checks;
    int errors;

    operand_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .base_address(base_address),
        .load_weight(load_weight), .load_input(load_input),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .weight_00(weight_00), .weight_01(weight_01), .weight_10(weight_10), .weight_11(weight_11),
        .weight_valid(weight_valid),
        .input_row0(input_row0), .input_row1(input_row1),
        .input_valid0(input_valid0), .input_valid1(input_valid1),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unified buffer: data returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // One transfer, checked cycle by cycle from T+1 until two cycles after done.
    task automatic run_transfer(input bit is_w, input bit both, input logic [ADDR_W-1:0] base,
                                input bit toggle);
        logic [DATA_W-1:0] e [4];
        logic [ADDR_W-1:0] a;
        int emit_len, last, j;
        logic [5:0] exp_ctrl, got_ctrl;
        logic [2*DATA_W-1:0] exp_rows;
        logic exp_v0, exp_v1;
        for (int i = 0; i < 4; i++) begin
            a = base + ADDR_W'(i);
            e[i] = mem[a];
        end
        emit_len = is_w ? 1 : (SKEW ? 3 : 2);
        last = 6 + emit_len;
        @(negedge clk);
        base_address = base;
        load_weight  = is_w | both;
        load_input   = ~is_w | both;
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            if (is_w && k == 6) begin
                for (int i = 0; i < 4; i++) mw[i] = e[i];
            end
            exp_v0 = 1'b0;
            exp_v1 = 1'b0;
            exp_rows = '0;
            j = k - 6;
            if (!is_w && j >= 0 && j < emit_len) begin
                if (SKEW) begin
                    if (j <= 1) begin exp_v0 = 1'b1; exp_rows[2*DATA_W-1:DATA_W] = e[j]; end
                    if (j >= 1) begin exp_v1 = 1'b1; exp_rows[DATA_W-1:0] = e[j+1]; end
                end else begin
                    exp_v0 = 1'b1;
                    exp_v1 = 1'b1;
                    exp_rows = {e[j], e[j+2]};
                end
            end
            exp_ctrl = {(k >= 1 && k <= 4), (k <= 5 + emit_len), (k == last),
                        (is_w && k == 6), exp_v0, exp_v1};
            got_ctrl = {mem_rd_en, busy, done, weight_valid, input_valid0, input_valid1};
            checks++;
            if (got_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL ctrl{rd,busy,done,wv,v0,v1} T+%0d base=%h got %b exp %b", k, base, got_ctrl, exp_ctrl);
            end
            if (exp_ctrl[5]) begin
                a = base + ADDR_W'(k - 1);
                checks++;
                if (mem_addr !== a) begin
                    errors++;
                    $display("FAIL mem_addr T+%0d got %h exp %h", k, mem_addr, a);
                end
            end
            checks++;
            if ({input_row0, input_row1} !== exp_rows) begin
                errors++;
                $display("FAIL rows T+%0d got %h exp %h", k, {input_row0, input_row1}, exp_rows);
            end
            checks++;
            if ({weight_00, weight_01, weight_10, weight_11} !== {mw[0], mw[1], mw[2], mw[3]}) begin
                errors++;
                $display("FAIL weights T+%0d got %h exp %h", k,
                         {weight_00, weight_01, weight_10, weight_11}, {mw[0], mw[1], mw[2], mw[3]});
            end
            // Stimulus for the next cycle; base changes after T must not matter.
            if (k == 1) base_address = ADDR_W'($urandom);
            if (toggle) begin
                if (k == 2) load_input = 1'b1;
                if (k == 3) begin load_input = 1'b0; load_weight = 1'b0; end
                if (k == 4) load_input = 1'b1;
            end else if (k == 3) begin
                load_weight = 1'b0;
                load_input  = 1'b0;
            end
        end
        load_weight = 1'b0;
        load_input  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_rd_en, busy, done, weight_valid, input_valid0, input_valid1, mem_addr,
             input_row0, input_row1, weight_00, weight_01, weight_10, weight_11} !== '0) begin
            errors++;
            $display("FAIL reset_state got nonzero outputs busy=%b rd=%b w=%h", busy, mem_rd_en,
                     {weight_00, weight_01, weight_10, weight_11});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_weight_load();
        for (int i = 0; i < 4; i++) mem[16 + i] = DATA_W'(i + 1);
        run_transfer(1'b1, 1'b0, ADDR_W'(16'h0010), 1'b0);
        checks++;
        if ({weight_00, weight_01, weight_10, weight_11} !== 32'h01020304) begin
            errors++;
            $display("FAIL weight_load_values got %h exp 01020304", {weight_00, weight_01, weight_10, weight_11});
        end
    endtask

    task automatic test_input_load();
        for (int i = 0; i < 4; i++) mem[32 + i] = DATA_W'(i + 5);
        run_transfer(1'b0, 1'b0, ADDR_W'(16'h0020), 1'b0);
    endtask

    task automatic test_wrap();
        run_transfer(1'b0, 1'b0, ADDR_W'(16'h1FFE), 1'b0);
        run_transfer(1'b1, 1'b0, ADDR_W'(16'h1FFF), 1'b0);
    endtask

    task automatic test_priority_and_busy();
        run_transfer(1'b1, 1'b1, ADDR_W'($urandom), 1'b0);
        run_transfer(1'b1, 1'b0, ADDR_W'($urandom), 1'b1);
    endtask

    task automatic test_reset_mid_transfer();
        @(negedge clk);
        base_address = ADDR_W'(16'h0100);
        load_weight  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) mw[i] = '0;
        checks++;
        if ({mem_rd_en, busy, done, weight_valid, input_valid0, input_valid1, mem_addr,
             input_row0, input_row1, weight_00, weight_01, weight_10, weight_11} !== '0) begin
            errors++;
            $display("FAIL reset_abort outputs not cleared rd=%b busy=%b addr=%h", mem_rd_en, busy, mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_rd_en, busy, done, weight_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_no_trigger cycle %0d got %b exp 0000", k,
                         {mem_rd_en, busy, done, weight_valid});
            end
        end
        load_weight = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_transfer(1'($urandom), 1'b0, ADDR_W'($urandom), 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        base_address = '0;
        load_weight = 1'b0;
        load_input = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
        for (int i = 0; i < 4; i++) mw[i] = '0;
        test_reset();
        test_weight_load();
        test_input_load();
        test_wrap();
        test_priority_and_busy();
        test_reset_mid_transfer();
        test_weight_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
